lsu_align: RTL and testbench

Load/store alignment unit between the pipeline MEM stage and the word-addressed data memory. It translates byte, halfword and word loads/stores (RV32I funct3 encoding) into whole-word memory accesses, performs sign/zero extension on loads and read-modify-write on sub-word stores, and flags misaligned, out-of-range or illegal accesses. The memory side has a combinational read port and a clocked word write.

---
 rtl/lsu_align.sv | 180 ++++++++++++++++++
 tb/tb_lsu_align.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load/store alignment unit between MEM stage and word-addressed data memory
module lsu_align #(
  parameter logic [31:0] DMEM_BASE = 32'h0010_0000,
  parameter int unsigned DMEM_SIZE = 32768
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] DM_A,
  output logic [31:0] DM_WD,
  output logic        DM_WE,
  input  logic [31:0] DM_RD
);

  typedef enum logic {IDLE = 1'b0, MERGE = 1'b1} state_t;

  localparam logic [32:0] BASE33  = {1'b0, DMEM_BASE};
  localparam logic [32:0] LIMIT33 = BASE33 + 33'(DMEM_SIZE) * 33'd4;

  state_t      state, state_nxt;
  logic        accept;
  logic        illegal, out_of_range, misaligned, req_err;
  logic        is_sw, is_sub;
  logic [31:0] dm_off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  logic [31:0] merge_word;
  logic [31:0] merge_addr;
  logic [1:0]  merge_lane;
  logic        merge_half;
  logic [15:0] merge_wdata;
  logic [31:0] merged_word;

  // Accepts are gated by RST_N so no write can leak out while reset is held.
  assign accept = req_valid && req_ready && RST_N;
  assign dm_off = {req_addr[31:2], 2'b00} - DMEM_BASE;

  always_comb begin
    illegal = 1'b1;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_store;
      default:                illegal = 1'b1;
    endcase
  end

  assign out_of_range = ({1'b0, req_addr} < BASE33) || ({1'b0, req_addr} >= LIMIT33);

  always_comb begin
    misaligned = 1'b0;
    case (req_funct3)
      3'b001, 3'b101: misaligned = req_addr[0];
      3'b010:         misaligned = |req_addr[1:0];
      default:        misaligned = 1'b0;
    endcase
  end

  assign req_err = illegal || out_of_range || misaligned;
  assign is_sw   = req_store && !req_err && (req_funct3 == 3'b010);
  assign is_sub  = req_store && !req_err && ((req_funct3 == 3'b000) || (req_funct3 == 3'b001));

  always_comb begin
    ld_byte = DM_RD[7:0];
    case (req_addr[1:0])
      2'd0: ld_byte = DM_RD[7:0];
      2'd1: ld_byte = DM_RD[15:8];
      2'd2: ld_byte = DM_RD[23:16];
      2'd3: ld_byte = DM_RD[31:24];
      default: ld_byte = DM_RD[7:0];
    endcase
    ld_half = req_addr[1] ? DM_RD[31:16] : DM_RD[15:0];
    load_data = '0;
    case (req_funct3)
      3'b000: load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001: load_data = {{16{ld_half[15]}}, ld_half};
      3'b010: load_data = DM_RD;
      3'b100: load_data = {24'd0, ld_byte};
      3'b101: load_data = {16'd0, ld_half};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    merged_word = merge_word;
    if (merge_half) begin
      if (merge_lane[1]) merged_word[31:16] = merge_wdata;
      else               merged_word[15:0]  = merge_wdata;
    end else begin
      case (merge_lane)
        2'd0: merged_word[7:0]   = merge_wdata[7:0];
        2'd1: merged_word[15:8]  = merge_wdata[7:0];
        2'd2: merged_word[23:16] = merge_wdata[7:0];
        2'd3: merged_word[31:24] = merge_wdata[7:0];
        default: merged_word = merge_word;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_sub) state_nxt = MERGE;
      MERGE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side outputs follow state combinationally, so reset in MERGE kills DM_WE at once.
  always_comb begin
    req_ready = (state == IDLE);
    DM_A      = dm_off;
    DM_WE     = 1'b0;
    DM_WD     = '0;
    if (state == MERGE) begin
      DM_A  = merge_addr;
      DM_WE = 1'b1;
      DM_WD = merged_word;
    end else if (accept && is_sw) begin
      DM_WE = 1'b1;
      DM_WD = req_wdata;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      merge_word  <= '0;
      merge_addr  <= '0;
      merge_lane  <= '0;
      merge_half  <= 1'b0;
      merge_wdata <= '0;
    end else if (accept && is_sub) begin
      merge_word  <= DM_RD;
      merge_addr  <= dm_off;
      merge_lane  <= req_addr[1:0];
      merge_half  <= req_funct3[0];
      merge_wdata <= req_wdata[15:0];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      if (state == MERGE) begin
        rsp_valid <= 1'b1;
      end else if (accept) begin
        if (req_err) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
        end else if (!req_store) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= load_data;
        end else if (is_sw) begin
          rsp_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// tb/tb_lsu_align.sv - directed bench for lsu_align with a word-array memory model
module tb_lsu_align;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] DM_A, DM_WD, DM_RD;
  logic        DM_WE;

  logic [31:0] mem [0:32767];
  logic        mem_init = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
    logic        chk_mem;
    int          idx;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[$];

  lsu_align dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .DM_A(DM_A), .DM_WD(DM_WD), .DM_WE(DM_WE), .DM_RD(DM_RD)
  );

  always #5 CLK = ~CLK;

  assign DM_RD = mem[DM_A[16:2]];

  always @(posedge CLK) begin
    if (!mem_init) begin
      for (int i = 0; i < 32768; i++) mem[i] <= 32'd0;
      mem[0]        <= 32'h0123_4567;
      mem[1]        <= 32'h80FF_7F01;
      mem[2]        <= 32'h1122_3344;
      mem[4]        <= 32'hCAFE_F00D;
      mem[15'h7FFF] <= 32'h55AA_55AA;
      mem_init      <= 1'b1;
    end else if (DM_WE) begin
      mem[DM_A[16:2]] <= DM_WD;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                              input logic err, input int lat, input int we, input logic cm,
                              input int idx, input logic [31:0] w);
    vec_t v;
    v.name = nm; v.store = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.exp_rdata = rd;
    v.exp_err = err; v.exp_lat = lat; v.exp_we = we; v.chk_mem = cm; v.idx = idx; v.exp_word = w;
    return v;
  endfunction

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int wes;
    logic [31:0] wd;
    @(negedge CLK);
    drive(v.store, v.f3, v.addr, v.wdata);
    #1;
    check({v.name, ".ready"}, 32'(req_ready), 32'd1);
    wes = 0;
    wd  = '0;
    if (DM_WE) begin wes++; wd = DM_WD; end
    @(negedge CLK);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 4) begin
      if (DM_WE) begin wes++; wd = DM_WD; end
      @(negedge CLK);
      lat++;
    end
    check({v.name, ".lat"}, 32'(lat), 32'(v.exp_lat));
    check({v.name, ".rdata"}, rsp_rdata, v.exp_rdata);
    check({v.name, ".err"}, 32'(rsp_err), 32'(v.exp_err));
    check({v.name, ".we"}, 32'(wes), 32'(v.exp_we));
    if (v.exp_we > 0) check({v.name, ".wd"}, wd, v.exp_word);
    if (v.chk_mem) check({v.name, ".mem"}, mem[v.idx], v.exp_word);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0010_0000; req_wdata = '0;

    vecs.push_back(mk("lb_l1",   0, 3'b000, 32'h0010_0005, 0, 32'h0000_007F, 0, 1, 0, 1, 1, 32'h80FF_7F01));
    vecs.push_back(mk("lbu_l1",  0, 3'b100, 32'h0010_0005, 0, 32'h0000_007F, 0, 1, 0, 1, 1, 32'h80FF_7F01));
    vecs.push_back(mk("lb_l2",   0, 3'b000, 32'h0010_0006, 0, 32'hFFFF_FFFF, 0, 1, 0, 1, 1, 32'h80FF_7F01));
    vecs.push_back(mk("lbu_l2",  0, 3'b100, 32'h0010_0006, 0, 32'h0000_00FF, 0, 1, 0, 1, 1, 32'h80FF_7F01));
    vecs.push_back(mk("lb_l3",   0, 3'b000, 32'h0010_0007, 0, 32'hFFFF_FF80, 0, 1, 0, 1, 1, 32'h80FF_7F01));
    vecs.push_back(mk("lh_hi",   0, 3'b001, 32'h0010_0006, 0, 32'hFFFF_80FF, 0, 1, 0, 1, 1, 32'h80FF_7F01));
    vecs.push_back(mk("lhu_hi",  0, 3'b101, 32'h0010_0006, 0, 32'h0000_80FF, 0, 1, 0, 1, 1, 32'h80FF_7F01));
    vecs.push_back(mk("lh_lo",   0, 3'b001, 32'h0010_0004, 0, 32'h0000_7F01, 0, 1, 0, 1, 1, 32'h80FF_7F01));
    vecs.push_back(mk("lw",      0, 3'b010, 32'h0010_0004, 0, 32'h80FF_7F01, 0, 1, 0, 1, 1, 32'h80FF_7F01));
    vecs.push_back(mk("sb",      1, 3'b000, 32'h0010_0009, 32'h0000_00AB, 0, 0, 2, 1, 1, 2, 32'h1122_AB44));
    vecs.push_back(mk("sh",      1, 3'b001, 32'h0010_000A, 32'h0000_BEEF, 0, 0, 2, 1, 1, 2, 32'hBEEF_AB44));
    vecs.push_back(mk("lw_mrg",  0, 3'b010, 32'h0010_0008, 0, 32'hBEEF_AB44, 0, 1, 0, 1, 2, 32'hBEEF_AB44));
    vecs.push_back(mk("sw",      1, 3'b010, 32'h0010_0000, 32'hDEAD_BEEF, 0, 0, 1, 1, 1, 0, 32'hDEAD_BEEF));
    vecs.push_back(mk("lw_sw",   0, 3'b010, 32'h0010_0000, 0, 32'hDEAD_BEEF, 0, 1, 0, 1, 0, 32'hDEAD_BEEF));
    vecs.push_back(mk("lw_last", 0, 3'b010, 32'h0011_FFFC, 0, 32'h55AA_55AA, 0, 1, 0, 1, 32'h7FFF, 32'h55AA_55AA));
    vecs.push_back(mk("e_lh",    0, 3'b001, 32'h0010_0001, 0, 0, 1, 1, 0, 1, 0, 32'hDEAD_BEEF));
    vecs.push_back(mk("e_sw",    1, 3'b010, 32'h0010_0002, 32'hFFFF_FFFF, 0, 1, 1, 0, 1, 0, 32'hDEAD_BEEF));
    vecs.push_back(mk("e_low",   0, 3'b010, 32'h000F_FFFC, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("e_high",  0, 3'b010, 32'h0012_0000, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("e_sbu",   1, 3'b100, 32'h0010_0000, 32'h0000_00FF, 0, 1, 1, 0, 1, 0, 32'hDEAD_BEEF));
    vecs.push_back(mk("e_f3",    0, 3'b011, 32'h0010_0000, 0, 0, 1, 1, 0, 1, 0, 32'hDEAD_BEEF));
    vecs.push_back(mk("e_shmis", 1, 3'b001, 32'h0010_0009, 32'h0000_1234, 0, 1, 1, 0, 1, 2, 32'hBEEF_AB44));

    repeat (3) @(negedge CLK);
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    check("rst.rsp_err", 32'(rsp_err), 32'd0);
    check("rst.we", 32'(DM_WE), 32'd0);
    check("rst.wd", DM_WD, 32'd0);
    RST_N = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back LW, SW, LW to one word
    @(negedge CLK);
    drive(1'b0, 3'b010, 32'h0010_0010, 32'd0);
    #1 check("b2b.ready0", 32'(req_ready), 32'd1);
    @(negedge CLK);
    check("b2b.v0", 32'(rsp_valid), 32'd1);
    check("b2b.rd0", rsp_rdata, 32'hCAFE_F00D);
    drive(1'b1, 3'b010, 32'h0010_0010, 32'h1234_5678);
    #1 check("b2b.ready1", 32'(req_ready), 32'd1);
    @(negedge CLK);
    check("b2b.v1", 32'(rsp_valid), 32'd1);
    check("b2b.rd1", rsp_rdata, 32'd0);
    drive(1'b0, 3'b010, 32'h0010_0010, 32'd0);
    #1 check("b2b.ready2", 32'(req_ready), 32'd1);
    @(negedge CLK);
    check("b2b.v2", 32'(rsp_valid), 32'd1);
    check("b2b.rd2", rsp_rdata, 32'h1234_5678);
    req_valid = 1'b0;
    @(negedge CLK);
    check("b2b.v3", 32'(rsp_valid), 32'd0);

    // Reset asserted during the MERGE write of an SB
    drive(1'b1, 3'b000, 32'h0010_0010, 32'h0000_0099);
    @(negedge CLK);
    req_valid = 1'b0;
    check("rm.we_merge", 32'(DM_WE), 32'd1);
    check("rm.a_merge", DM_A, 32'h0000_0010);
    RST_N = 1'b0;
    #1;
    check("rm.we_drop", 32'(DM_WE), 32'd0);
    check("rm.wd", DM_WD, 32'd0);
    check("rm.ready", 32'(req_ready), 32'd1);
    check("rm.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rm.rsp_rdata", rsp_rdata, 32'd0);
    check("rm.rsp_err", 32'(rsp_err), 32'd0);
    @(negedge CLK);
    check("rm.mem", mem[4], 32'h1234_5678);
    check("rm.rsp_valid2", 32'(rsp_valid), 32'd0);
    RST_N = 1'b1;
    #1 check("rm.ready_rel", 32'(req_ready), 32'd1);
    @(negedge CLK);
    check("rm.rsp_valid3", 32'(rsp_valid), 32'd0);

    // SH accepted with an LW queued behind it
    drive(1'b1, 3'b001, 32'h0010_0012, 32'h0000_1357);
    #1 check("st.ready0", 32'(req_ready), 32'd1);
    @(negedge CLK);
    check("st.ready1", 32'(req_ready), 32'd0);
    check("st.we", 32'(DM_WE), 32'd1);
    check("st.wd", DM_WD, 32'h1357_5678);
    drive(1'b0, 3'b010, 32'h0010_0010, 32'd0);
    #1 check("st.ready1b", 32'(req_ready), 32'd0);
    @(negedge CLK);
    check("st.ready2", 32'(req_ready), 32'd1);
    check("st.v_sh", 32'(rsp_valid), 32'd1);
    check("st.rd_sh", rsp_rdata, 32'd0);
    @(negedge CLK);
    req_valid = 1'b0;
    check("st.v_lw", 32'(rsp_valid), 32'd1);
    check("st.rd_lw", rsp_rdata, 32'h1357_5678);
    @(negedge CLK);
    check("st.v_end", 32'(rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
